// File: rtl/pic_pkg.sv
// pic_pkg
//   Shared definitions for the nested priority resolver:
//   - OCW2-style {R,SL,EOI} command encodings carried on eoi_cmd
//   - handshake state enumeration
package pic_pkg;

   localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
   localparam logic [2:0] EOI_NS       = 3'b001;
   localparam logic [2:0] EOI_NOP      = 3'b010;
   localparam logic [2:0] EOI_SPEC     = 3'b011;
   localparam logic [2:0] ROT_AEOI_SET = 3'b100;
   localparam logic [2:0] ROT_NS       = 3'b101;
   localparam logic [2:0] SET_PRI      = 3'b110;
   localparam logic [2:0] ROT_SPEC     = 3'b111;

   typedef enum logic {
      IDLE = 1'b0,
      ACK1 = 1'b1
   } state_t;

endpackage

// File: rtl/prio_resolver_nested_if.sv
// prio_resolver_nested_if
//   Bundles the request/mask inputs, INTA handshake, EOI command bus and
//   resolver outputs.
//   slave  : resolver side (requests/commands in, int_req/sel/isr out)
//   master : control/IRR side (the mirror image)
//   Optional macro SPECIAL_MASK_EN adds the smm signal.
interface prio_resolver_nested_if #(
   parameter int NUM_IRQ = 8
);
   localparam int L = $clog2(NUM_IRQ);

   logic [NUM_IRQ-1:0] irr;
   logic [NUM_IRQ-1:0] imr;
   logic               inta_1;
   logic               inta_2;
   logic               eoi_valid;
   logic [2:0]         eoi_cmd;
   logic [L-1:0]       eoi_level;
   logic               aeoi;
`ifdef SPECIAL_MASK_EN
   logic               smm;
`endif
   logic               int_req;
   logic [NUM_IRQ-1:0] irr_clr;
   logic [NUM_IRQ-1:0] isr;
   logic [L-1:0]       sel;
   logic               vec_valid;
   logic               spurious;
   logic [L-1:0]       lowest_pri;

   modport slave (
      input  irr, imr, inta_1, inta_2, eoi_valid, eoi_cmd, eoi_level, aeoi,
`ifdef SPECIAL_MASK_EN
      input  smm,
`endif
      output int_req, irr_clr, isr, sel, vec_valid, spurious, lowest_pri
   );

   modport master (
      output irr, imr, inta_1, inta_2, eoi_valid, eoi_cmd, eoi_level, aeoi,
`ifdef SPECIAL_MASK_EN
      output smm,
`endif
      input  int_req, irr_clr, isr, sel, vec_valid, spurious, lowest_pri
   );

endinterface

// File: rtl/prio_find.sv
// prio_find
//   Combinational rotating priority encoder.
//   i_vec    : candidate bit vector
//   i_lowest : current lowest-priority level
//   o_found  : any bit of i_vec set
//   o_level  : level of the highest-priority set bit
//   o_rank   : its rank, (level - i_lowest - 1) mod NUM_IRQ, 0 = highest
module prio_find #(
   parameter int NUM_IRQ = 8,
   localparam int L = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] i_vec,
   input  logic [L-1:0]       i_lowest,
   output logic               o_found,
   output logic [L-1:0]       o_level,
   output logic [L-1:0]       o_rank
);
   // w_idx[r] is the level that currently holds rank r; the L-bit add
   // wraps naturally because NUM_IRQ is a power of two.
   logic [L-1:0] w_idx [NUM_IRQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_IRQ; gi++) begin : g_idx
         assign w_idx[gi] = i_lowest + L'(gi + 1);
      end
   endgenerate

   // Scan from the lowest rank up so the highest-priority hit is written last.
   always_comb begin
      o_found = 1'b0;
      o_level = '0;
      o_rank  = '0;
      for (int r = NUM_IRQ - 1; r >= 0; r--) begin
         if (i_vec[w_idx[r]]) begin
            o_found = 1'b1;
            o_level = w_idx[r];
            o_rank  = L'(r);
         end
      end
   end

endmodule

// File: rtl/prio_resolver_nested.sv
// prio_resolver_nested
//   Clocked PIC priority resolver with internal ISR, fully nested priority,
//   automatic/specific rotation, EOI commands and auto-EOI.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : prio_resolver_nested_if.slave (requests, INTA, EOI in;
//           int_req, irr_clr, isr, sel, vec_valid, spurious, lowest_pri out)
//   Optional macro SPECIAL_MASK_EN enables special mask mode via bus.smm.
module prio_resolver_nested
   import pic_pkg::*;
#(
   parameter int NUM_IRQ = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   prio_resolver_nested_if.slave  bus
);
   localparam int L = $clog2(NUM_IRQ);

   state_t             r_state, w_state_next;
   logic [NUM_IRQ-1:0] r_isr, w_isr_next;
   logic [NUM_IRQ-1:0] r_irr_clr, w_irr_clr_next;
   logic [L-1:0]       r_lowest, w_lowest_next;
   logic [L-1:0]       r_sel, w_sel_next;
   logic               r_rot_aeoi, w_rot_aeoi_next;
   logic               r_spur_pend, w_spur_pend_next;
   logic               r_spurious, w_spurious_next;
   logic               r_vec_valid, w_vec_valid_next;
   logic               r_int_req, w_int_req_next;

   logic [NUM_IRQ-1:0] w_req;
   logic [NUM_IRQ-1:0] w_isv_vec;
   logic               w_cand_found, w_isv_found;
   logic [L-1:0]       w_cand_lvl, w_cand_rank, w_isv_lvl, w_isv_rank;

   assign w_req = bus.irr & ~bus.imr;

`ifdef SPECIAL_MASK_EN
   // In special mask mode masked in-service levels do not block and are
   // invisible to non-specific EOI.
   assign w_isv_vec = bus.smm ? (r_isr & ~bus.imr) : r_isr;
`else
   assign w_isv_vec = r_isr;
`endif

   prio_find #(.NUM_IRQ(NUM_IRQ)) u_find_req (
      .i_vec    (w_req),
      .i_lowest (r_lowest),
      .o_found  (w_cand_found),
      .o_level  (w_cand_lvl),
      .o_rank   (w_cand_rank)
   );

   prio_find #(.NUM_IRQ(NUM_IRQ)) u_find_isr (
      .i_vec    (w_isv_vec),
      .i_lowest (r_lowest),
      .o_found  (w_isv_found),
      .o_level  (w_isv_lvl),
      .o_rank   (w_isv_rank)
   );

   always_comb begin
`ifdef SPECIAL_MASK_EN
      if (bus.smm)
         w_int_req_next = w_cand_found && !r_isr[w_cand_lvl];
      else
         w_int_req_next = w_cand_found && (!w_isv_found || (w_cand_rank < w_isv_rank));
`else
      w_int_req_next = w_cand_found && (!w_isv_found || (w_cand_rank < w_isv_rank));
`endif
   end

   always_comb begin
      w_state_next     = r_state;
      w_isr_next       = r_isr;
      w_lowest_next    = r_lowest;
      w_sel_next       = r_sel;
      w_rot_aeoi_next  = r_rot_aeoi;
      w_spur_pend_next = r_spur_pend;
      w_irr_clr_next   = '0;
      w_vec_valid_next = 1'b0;
      w_spurious_next  = 1'b0;

      // EOI commands are applied first so a simultaneous INTA set wins.
      if (bus.eoi_valid) begin
         case (bus.eoi_cmd)
            EOI_NS: if (w_isv_found) w_isr_next[w_isv_lvl] = 1'b0;
            EOI_SPEC: w_isr_next[bus.eoi_level] = 1'b0;
            ROT_NS: if (w_isv_found) begin
               w_isr_next[w_isv_lvl] = 1'b0;
               w_lowest_next         = w_isv_lvl;
            end
            ROT_SPEC: begin
               w_isr_next[bus.eoi_level] = 1'b0;
               w_lowest_next             = bus.eoi_level;
            end
            SET_PRI:      w_lowest_next   = bus.eoi_level;
            ROT_AEOI_SET: w_rot_aeoi_next = 1'b1;
            ROT_AEOI_CLR: w_rot_aeoi_next = 1'b0;
            default: ;
         endcase
      end

      case (r_state)
         IDLE: begin
            if (bus.inta_1) begin
               w_state_next = ACK1;
               if (w_cand_found) begin
                  w_sel_next                 = w_cand_lvl;
                  w_isr_next[w_cand_lvl]     = 1'b1;
                  w_irr_clr_next[w_cand_lvl] = 1'b1;
                  w_spur_pend_next           = 1'b0;
               end else begin
                  w_sel_next       = r_lowest;
                  w_spur_pend_next = 1'b1;
               end
            end
         end
         ACK1: begin
            if (bus.inta_2) begin
               w_state_next     = IDLE;
               w_vec_valid_next = 1'b1;
               w_spurious_next  = r_spur_pend;
               // A spurious acknowledge never touched the ISR, so auto-EOI
               // has nothing to retire. Auto-rotation takes precedence over
               // a rotate command arriving in the same cycle.
               if (bus.aeoi && !r_spur_pend) begin
                  w_isr_next[r_sel] = 1'b0;
                  if (r_rot_aeoi) w_lowest_next = r_sel;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_isr       <= '0;
         r_irr_clr   <= '0;
         r_lowest    <= L'(NUM_IRQ - 1);
         r_sel       <= '0;
         r_rot_aeoi  <= 1'b0;
         r_spur_pend <= 1'b0;
         r_spurious  <= 1'b0;
         r_vec_valid <= 1'b0;
         r_int_req   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_isr       <= w_isr_next;
         r_irr_clr   <= w_irr_clr_next;
         r_lowest    <= w_lowest_next;
         r_sel       <= w_sel_next;
         r_rot_aeoi  <= w_rot_aeoi_next;
         r_spur_pend <= w_spur_pend_next;
         r_spurious  <= w_spurious_next;
         r_vec_valid <= w_vec_valid_next;
         r_int_req   <= w_int_req_next;
      end
   end

   assign bus.int_req    = r_int_req;
   assign bus.irr_clr    = r_irr_clr;
   assign bus.isr        = r_isr;
   assign bus.sel        = r_sel;
   assign bus.vec_valid  = r_vec_valid;
   assign bus.spurious   = r_spurious;
   assign bus.lowest_pri = r_lowest;

endmodule

// File: tb/tb_prio_resolver_nested.sv
// tb_prio_resolver_nested
//   Directed bench for prio_resolver_nested (NUM_IRQ = 8). Expected
//   acknowledge results are queued when inta_1 is driven and checked when
//   vec_valid appears.
module tb_prio_resolver_nested;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   prio_resolver_nested_if #(.NUM_IRQ(8)) bus ();

   prio_resolver_nested #(.NUM_IRQ(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [2:0] sel;
      logic       spur;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic eoi(input logic [2:0] cmd, input logic [2:0] lvl);
      bus.eoi_valid = 1'b1;
      bus.eoi_cmd   = cmd;
      bus.eoi_level = lvl;
   endtask

   task automatic eoi_off();
      bus.eoi_valid = 1'b0;
      bus.eoi_cmd   = 3'b010;
   endtask

   // Drives inta_1 for one cycle and records the acknowledge it should yield.
   task automatic do_inta1(input logic [2:0] esel, input logic espur);
      exp_t e;
      e.sel  = esel;
      e.spur = espur;
      exp_q.push_back(e);
      bus.inta_1 = 1'b1;
      tick();
      bus.inta_1 = 1'b0;
   endtask

   // Drives inta_2 for one cycle; vec_valid must follow one cycle later.
   task automatic do_inta2();
      exp_t e;
      bus.inta_2 = 1'b1;
      tick();
      bus.inta_2 = 1'b0;
      chk("vec_valid", 32'(bus.vec_valid), 32'd1);
      if (exp_q.size() == 0) begin
         chk("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk("ack_sel", 32'(bus.sel), 32'(e.sel));
         chk("ack_spurious", 32'(bus.spurious), 32'(e.spur));
         $display("TXN ack sel=%0d spurious=%0d isr=%02h lowest=%0d",
                  bus.sel, bus.spurious, bus.isr, bus.lowest_pri);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_int_req"}, 32'(bus.int_req), 32'd0);
      chk({tag, "_irr_clr"}, 32'(bus.irr_clr), 32'd0);
      chk({tag, "_isr"}, 32'(bus.isr), 32'd0);
      chk({tag, "_sel"}, 32'(bus.sel), 32'd0);
      chk({tag, "_vec_valid"}, 32'(bus.vec_valid), 32'd0);
      chk({tag, "_spurious"}, 32'(bus.spurious), 32'd0);
      chk({tag, "_lowest_pri"}, 32'(bus.lowest_pri), 32'd7);
   endtask

   initial begin
      reset         = 1'b1;
      bus.irr       = '0;
      bus.imr       = '0;
      bus.inta_1    = 1'b0;
      bus.inta_2    = 1'b0;
      bus.eoi_valid = 1'b0;
      bus.eoi_cmd   = 3'b010;
      bus.eoi_level = '0;
      bus.aeoi      = 1'b0;
`ifdef SPECIAL_MASK_EN
      bus.smm       = 1'b0;
`endif
      tick();
      tick();
      chk_reset_vals("reset");
      reset = 1'b0;
      tick();

      // Default priority: level 3 beats level 5.
      bus.irr = 8'h28;
      tick();
      chk("dflt_int_req", 32'(bus.int_req), 32'd1);
      do_inta1(3'd3, 1'b0);
      chk("dflt_sel", 32'(bus.sel), 32'd3);
      chk("dflt_isr", 32'(bus.isr), 32'h08);
      chk("dflt_irr_clr", 32'(bus.irr_clr), 32'h08);
      bus.irr = 8'h20;
      tick();
      chk("dflt_irr_clr_pulse", 32'(bus.irr_clr), 32'h00);
      do_inta2();
      tick();
      chk("dflt_vec_pulse", 32'(bus.vec_valid), 32'd0);

      // Nesting: lower priority blocked, higher priority passes.
      chk("nest_block", 32'(bus.int_req), 32'd0);
      bus.irr = 8'h02;
      tick();
      chk("nest_pass", 32'(bus.int_req), 32'd1);

      // Rotate on non-specific EOI.
      bus.irr = 8'h0C;
      eoi(3'b101, 3'd0);
      tick();
      eoi_off();
      chk("rot_isr", 32'(bus.isr), 32'h00);
      chk("rot_lowest", 32'(bus.lowest_pri), 32'd3);
      tick();
      chk("rot_int_req", 32'(bus.int_req), 32'd1);
      do_inta1(3'd2, 1'b0);
      chk("rot_sel", 32'(bus.sel), 32'd2);
      chk("rot_isr_set", 32'(bus.isr), 32'h04);
      bus.irr = 8'h08;
      do_inta2();
      eoi(3'b001, 3'd0);
      tick();
      eoi_off();
      chk("ns_eoi_isr", 32'(bus.isr), 32'h00);
      chk("ns_eoi_lowest", 32'(bus.lowest_pri), 32'd3);

      // Auto-EOI with rotation.
      bus.aeoi = 1'b1;
      bus.irr  = 8'h01;
      eoi(3'b100, 3'd0);
      tick();
      eoi_off();
      tick();
      chk("aeoi_int_req", 32'(bus.int_req), 32'd1);
      do_inta1(3'd0, 1'b0);
      chk("aeoi_isr_set", 32'(bus.isr), 32'h01);
      bus.irr = 8'h00;
      do_inta2();
      chk("aeoi_isr_clr", 32'(bus.isr), 32'h00);
      chk("aeoi_lowest", 32'(bus.lowest_pri), 32'd0);
      bus.aeoi = 1'b0;
      eoi(3'b000, 3'd0);
      tick();

      // Set priority back to level 7 lowest, then a spurious acknowledge.
      eoi(3'b110, 3'd7);
      tick();
      eoi_off();
      chk("setpri_lowest", 32'(bus.lowest_pri), 32'd7);
      chk("setpri_isr", 32'(bus.isr), 32'h00);
      do_inta1(3'd7, 1'b1);
      chk("spur_isr", 32'(bus.isr), 32'h00);
      chk("spur_irr_clr", 32'(bus.irr_clr), 32'h00);
      chk("spur_sel", 32'(bus.sel), 32'd7);
      do_inta2();
      chk("spur_isr_after", 32'(bus.isr), 32'h00);

      // Simultaneous inta_1 and specific EOI on the same bit: set wins.
      bus.irr = 8'h81;
      tick();
      do_inta1(3'd0, 1'b0);
      chk("coll_isr0", 32'(bus.isr), 32'h01);
      bus.irr = 8'h80;
      do_inta2();
      chk("coll_nest_block", 32'(bus.int_req), 32'd0);
      eoi(3'b011, 3'd7);
      do_inta1(3'd7, 1'b0);
      eoi_off();
      chk("coll_set_wins", 32'(bus.isr), 32'h81);
      chk("coll_irr_clr", 32'(bus.irr_clr), 32'h80);
      bus.irr = 8'h00;
      do_inta2();

      // Rotate on specific EOI, then non-specific EOIs down to empty.
      eoi(3'b111, 3'd0);
      tick();
      chk("rspec_isr", 32'(bus.isr), 32'h80);
      chk("rspec_lowest", 32'(bus.lowest_pri), 32'd0);
      eoi(3'b001, 3'd0);
      tick();
      chk("ns_last_isr", 32'(bus.isr), 32'h00);
      eoi(3'b101, 3'd0);
      tick();
      eoi_off();
      chk("ns_empty_isr", 32'(bus.isr), 32'h00);
      chk("ns_empty_lowest", 32'(bus.lowest_pri), 32'd0);

      // Reset in ACK1: immediate clear, later inta_2 ignored.
      bus.irr = 8'h10;
      tick();
      do_inta1(3'd4, 1'b0);
      chk("rst_pre_sel", 32'(bus.sel), 32'd4);
      chk("rst_pre_isr", 32'(bus.isr), 32'h10);
      reset = 1'b1;
      #2;
      chk_reset_vals("async_rst");
      exp_q.delete();
      tick();
      reset = 1'b0;
      bus.irr = 8'h00;
      bus.inta_2 = 1'b1;
      tick();
      bus.inta_2 = 1'b0;
      chk("rst_no_vec", 32'(bus.vec_valid), 32'd0);
      tick();
      chk("rst_no_vec2", 32'(bus.vec_valid), 32'd0);
      chk("rst_isr_after", 32'(bus.isr), 32'h00);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prio_resolver_nested.md
# prio_resolver_nested

Parametrised, clocked successor of the PIC priority resolver: arbitrates NUM_IRQ interrupt request lines against a mask, tracks the in-service register (ISR) internally, and supports fully nested priority, automatic and specific rotation, EOI commands and auto-EOI. It sits between the IRR/IMR registers and the control logic. It raises `int_req`, answers the two-pulse INTA handshake with the winning level, and tells the IRR which bit to clear.

## Interface
- NUM_IRQ, 8: number of request levels; power of two, 2..32. L = $clog2(NUM_IRQ).
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- irr  in  NUM_IRQ  pending requests from IRR
- imr  in  NUM_IRQ  mask, 1 = masked
- inta_1  in  1  one-cycle pulse, first INTA
- inta_2  in  1  one-cycle pulse, second INTA
- eoi_valid  in  1  one-cycle command strobe
- eoi_cmd  in  3  {R,SL,EOI}, OCW2 encoding
- eoi_level  in  L  level for specific commands
- aeoi  in  1  auto-EOI mode
- smm  in  1  special mask mode (only with SPECIAL_MASK_EN)
- int_req  out  1  registered interrupt request to control
- irr_clr  out  NUM_IRQ  one-hot, one-cycle pulse clearing IRR bit
- isr  out  NUM_IRQ  current in-service register
- sel  out  L  level latched at inta_1
- vec_valid  out  1  one-cycle pulse at inta_2, sel valid
- spurious  out  1  high with vec_valid when no request existed at inta_1
- lowest_pri  out  L  current lowest-priority level

## Operation
- Rank of level i = (i − lowest_pri − 1) mod NUM_IRQ, truncated to L bits; rank 0 is highest.
- Candidate: the highest-rank bit of irr & ~imr.
- In-service level: the highest-rank set ISR bit.
- Fully nested rule: int_req_next = candidate exists AND (ISR empty OR candidate rank < in-service rank).
- States:
  - IDLE: on inta_1 → ACK1, which latches sel = candidate, sets isr[sel] and pulses irr_clr[sel].
  - Spurious case: if no candidate exists at inta_1, sel = (lowest_pri) and spurious = 1; ISR and IRR are untouched.
  - ACK1: on inta_2 → IDLE with vec_valid = 1 for one cycle.
  - Auto-EOI: if aeoi = 1, clear isr[sel]; if rot_aeoi = 1, also set lowest_pri := sel.
  - inta_1 while in ACK1 is ignored. inta_2 in IDLE is ignored.
- eoi_cmd on eoi_valid:
  - 001 non-specific EOI: clear the in-service level bit.
  - 011 specific EOI: clear isr[eoi_level].
  - 101 rotate on non-specific EOI: clear the in-service level bit; lowest_pri := that level.
  - 111 rotate on specific EOI: clear isr[eoi_level]; lowest_pri := eoi_level.
  - 110 set priority: lowest_pri := eoi_level, ISR unchanged.
  - 100 / 000: set / clear the internal rot_aeoi flag.
  - 010: no-op.
  - Non-specific EOI commands with an empty ISR change nothing.
- Simultaneous inta_1 and EOI in one cycle:
  - Both take effect.
  - The candidate and in-service level use pre-update state.
  - If both target the same ISR bit, set wins.

## Timing
- Reset values: int_req 0, irr_clr 0, isr 0, sel 0, vec_valid 0, spurious 0, lowest_pri NUM_IRQ−1, rot_aeoi 0, state IDLE.
- Latency from irr/imr change to int_req: 1 cycle.
- Latency from inta_1 to isr/irr_clr/sel: 1 cycle. irr_clr is high exactly one cycle.
- Latency from inta_2 to vec_valid: 1 cycle.
- EOI and priority updates are visible on isr and lowest_pri 1 cycle after the strobe; int_req re-evaluates 1 cycle after that.
- int_req stays computed during ACK1; control logic ignores it until vec_valid.
- Reset asserted mid-handshake: immediate return to reset values; a later inta_2 in IDLE is ignored.

## Configuration
- SPECIAL_MASK_EN defined:
  - The smm port exists.
  - When smm = 1, int_req_next = candidate exists AND isr[candidate] = 0.
  - Masked ISR bits are also excluded from the in-service level used by non-specific EOI.
- SPECIAL_MASK_EN undefined:
  - The smm port is absent.
  - Fully nested rule only.

## Structure
- Shared package pic_pkg holds:
  - eoi_cmd encodings as localparams: EOI_NS, EOI_SPEC, ROT_NS, ROT_SPEC, SET_PRI, ROT_AEOI_SET, ROT_AEOI_CLR.
  - State enum {IDLE, ACK1}.
- Sub-module prio_find: combinational, NUM_IRQ-bit vector + lowest_pri → found flag, level, rank.
  - Instantiated twice: once on the masked IRR, once on the ISR.

## Test plan
- Default priority: irr=8'h28, imr=0, ISR empty.
  - Expect int_req=1 after 1 cycle.
  - inta_1 → sel=3, isr=8'h08, irr_clr=8'h08; inta_2 → vec_valid=1.
- Nesting: isr=8'h08, irr=8'h20 → int_req=0; irr=8'h02 → int_req=1.
- Rotation: with isr=8'h08, issue eoi_cmd=101.
  - Expect isr=0, lowest_pri=3.
  - Then irr=8'h0C → int_req=1; inta_1 → sel=2.
- Auto-EOI rotate: aeoi=1, ROT_AEOI_SET, irr=8'h01, full handshake.
  - After inta_2 expect isr=0, lowest_pri=0.
- Spurious: inta_1 with irr=0 → after inta_2, vec_valid=1, spurious=1, sel=7, isr unchanged.
- Reset while in ACK1 → all outputs at reset values; a following inta_2 produces no vec_valid.
